fdiv_arb: RTL

FDIV_ARB -- requirements
Module: fdiv_arb

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fdiv_resq.sv | 57 +++++
 rtl/fdiv_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the fdiv arbiter slice
package fpu_pkg;

    // FP word width carried on every datapath and queue port
    localparam int FW   = 32;

    // Number of requesters sharing the divider
    localparam int NREQ = 2;

    // Requester identifier carried alongside each in-flight op
    typedef logic req_id_t;

    // One stage of the tag pipe that shadows the divider latency
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // Requester that holds priority when both are eligible
    function automatic req_id_t rr_pick(input logic elig0, input logic elig1,
                                        input req_id_t ptr);
        if (elig0 && elig1) begin
            return ptr;
        end
        if (elig1) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/fdiv_resq.sv
// rtl/fdiv_resq.sv - per-requester result FIFO with combinational head
module fdiv_resq #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok;

    // A pop on an empty queue is ignored so occupancy can never underflow
    assign pop_ok = pop && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible through a non-empty head
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fdiv_arb.sv
// rtl/fdiv_arb.sv - round-robin arbiter sharing one pipelined fdiv between two requesters
module fdiv_arb
    import fpu_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          req0_valid,
    input  logic [FW-1:0] req0_x,
    input  logic [FW-1:0] req0_y,
    output logic          req0_ready,

    input  logic          req1_valid,
    input  logic [FW-1:0] req1_x,
    input  logic [FW-1:0] req1_y,
    output logic          req1_ready,

    output logic          res0_valid,
    output logic [FW-1:0] res0_data,
    input  logic          res0_ready,

    output logic          res1_valid,
    output logic [FW-1:0] res1_data,
    input  logic          res1_ready,

    output logic [FW-1:0] dv_x,
    output logic [FW-1:0] dv_y,
    input  logic [FW-1:0] dv_res,

    output logic          busy
);

    // Credit must be able to hold the value DEPTH itself
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] res_ready;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] accept;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] q_empty;
    logic [FW-1:0]   q_head [NREQ];
    logic [CW-1:0]   credit [NREQ];

    req_id_t         ptr;
    req_id_t         gnt_id;
    logic            gnt_any;
    tag_t            tag [LAT];
    logic            tag_busy;

    assign req_valid = {req1_valid, req0_valid};
    assign res_ready = {res1_ready, res0_ready};

    // A requester may issue only while its in-flight plus queued count leaves room
    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            elig[n] = req_valid[n] && (credit[n] < CW'(DEPTH));
        end
    end

    // Round-robin grant; held off entirely while reset is asserted
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rstn && (elig != '0)) begin
            gnt_any = 1'b1;
            gnt_id  = rr_pick(elig[0], elig[1], ptr);
        end
    end

    assign accept[0]  = gnt_any && (gnt_id == 1'b0);
    assign accept[1]  = gnt_any && (gnt_id == 1'b1);
    assign req0_ready = accept[0];
    assign req1_ready = accept[1];

    // Operands go straight to the divider in the grant cycle
    always_comb begin
        dv_x = '0;
        dv_y = '0;
        if (accept[0]) begin
            dv_x = req0_x;
            dv_y = req0_y;
        end else if (accept[1]) begin
            dv_x = req1_x;
            dv_y = req1_y;
        end
    end

    // Priority moves to the requester that was not just served
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (gnt_any) begin
            ptr <= ~gnt_id;
        end
    end

    // Tag pipe tracks which requester owns the result emerging LAT cycles later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                tag[i] <= '0;
            end
        end else begin
            tag[0].valid <= gnt_any;
            tag[0].id    <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= tag[i-1];
            end
        end
    end

    // Route the emerging result to its owner's queue; credit guarantees room
    always_comb begin
        push    = '0;
        push[0] = tag[LAT-1].valid && (tag[LAT-1].id == 1'b0);
        push[1] = tag[LAT-1].valid && (tag[LAT-1].id == 1'b1);
    end

    // A consumer handshake only counts when there is something to take
    always_comb begin
        for (int n = 0; n < NREQ; n++) begin
            pop[n] = res_ready[n] && !q_empty[n];
        end
    end

    // Credit counts ops from accept until their result is popped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < NREQ; n++) begin
                credit[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NREQ; n++) begin
                case ({accept[n], pop[n]})
                    2'b10:   credit[n] <= credit[n] + CW'(1);
                    2'b01:   credit[n] <= credit[n] - CW'(1);
                    default: credit[n] <= credit[n];
                endcase
            end
        end
    end

    fdiv_resq #(.DEPTH(DEPTH), .W(FW)) u_resq0 (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push[0]),
        .push_data (dv_res),
        .pop       (pop[0]),
        .empty     (q_empty[0]),
        .head      (q_head[0])
    );

    fdiv_resq #(.DEPTH(DEPTH), .W(FW)) u_resq1 (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push[1]),
        .push_data (dv_res),
        .pop       (pop[1]),
        .empty     (q_empty[1]),
        .head      (q_head[1])
    );

    assign res0_valid = !q_empty[0];
    assign res1_valid = !q_empty[1];
    assign res0_data  = q_head[0];
    assign res1_data  = q_head[1];

    // Any live tag means an op is still inside the divider
    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            tag_busy = tag_busy | tag[i].valid;
        end
    end

    assign busy = tag_busy || !q_empty[0] || !q_empty[1];

endmodule
